reg_file_ram_2r1w: RTL and testbench

- Two-read, one-write register file: 16 words × 32 bits, with registered (synchronous) read outputs.
- Serves as the general-purpose register file of the pipelined CPU.
- Read addresses are driven in the fetch (I) stage and data is consumed one cycle later in the decode (D) stage.
- The write port is driven by the writeback (W) stage.
- The pipeline forwards the value written in the previous cycle externally, so the block returns old data on a same-cycle read/write collision.

---
 rtl/reg_file_ram_2r1w.sv | 48 ++++
 tb/tb_reg_file_ram_2r1w.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/reg_file_ram_2r1w.sv
// Two-read, one-write register file with registered read ports.
// Same-edge read/write collisions return the old word; forwarding happens outside.
module reg_file_ram_2r1w #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wren,
   input  logic [ADDR_WIDTH-1:0] wraddress,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  rden_1,
   input  logic [ADDR_WIDTH-1:0] rdaddress_1,
   output logic [DATA_WIDTH-1:0] q_1,
   input  logic                  rden_2,
   input  logic [ADDR_WIDTH-1:0] rdaddress_2,
   output logic [DATA_WIDTH-1:0] q_2
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the storage array is reset on purpose, so it builds as flops rather
   // than a RAM macro; the CPU relies on every register reading 0 after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wren) begin
         mem[wraddress] <= data;
      end
   end

   // NOTE: non-blocking updates mean the reads below see mem as it was before
   // this edge's write, which is exactly the old-data collision behaviour.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_1 <= '0;
         q_2 <= '0;
      end else begin
         if (rden_1) q_1 <= mem[rdaddress_1];
         if (rden_2) q_2 <= mem[rdaddress_2];
      end
   end

endmodule

// File: tb/tb_reg_file_ram_2r1w.sv
// Self-checking bench for reg_file_ram_2r1w: directed steps, then random
// traffic against an array-based reference model.
module tb_reg_file_ram_2r1w;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wren = 1'b0;
   logic [3:0]  wraddress = '0;
   logic [31:0] data = '0;
   logic        rden_1 = 1'b0;
   logic [3:0]  rdaddress_1 = '0;
   logic [31:0] q_1;
   logic        rden_2 = 1'b0;
   logic [3:0]  rdaddress_2 = '0;
   logic [31:0] q_2;

   int tests = 0;
   int fails = 0;

   logic [31:0] m_mem [16];
   logic [31:0] m_q1;
   logic [31:0] m_q2;

   reg_file_ram_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
      .clk(clk), .reset(reset),
      .wren(wren), .wraddress(wraddress), .data(data),
      .rden_1(rden_1), .rdaddress_1(rdaddress_1), .q_1(q_1),
      .rden_2(rden_2), .rdaddress_2(rdaddress_2), .q_2(q_2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_q1 = '0;
      m_q2 = '0;
   endtask

   // One clock: drive inputs, take the edge, update the model, sample 1 ns later.
   task automatic step(input string tag, input logic we, input logic [3:0] wa,
                       input logic [31:0] d, input logic r1, input logic [3:0] a1,
                       input logic r2, input logic [3:0] a2);
      wren = we; wraddress = wa; data = d;
      rden_1 = r1; rdaddress_1 = a1;
      rden_2 = r2; rdaddress_2 = a2;
      @(posedge clk);
      if (reset) begin
         model_clear();
      end else begin
         if (r1) m_q1 = m_mem[a1];
         if (r2) m_q2 = m_mem[a2];
         if (we) m_mem[wa] = d;
      end
      #1;
      check({tag, "_q1"}, q_1, m_q1);
      check({tag, "_q2"}, q_2, m_q2);
   endtask

   initial begin
      model_clear();

      // Power-on reset, then preload a few words and read them back
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      step("pre_w0", 1'b1, 4'd0,  32'hCAFE0000, 1'b0, 4'd0, 1'b0, 4'd0);
      step("pre_w1", 1'b1, 4'd4,  32'h44444444, 1'b0, 4'd0, 1'b0, 4'd0);
      step("pre_w2", 1'b1, 4'd11, 32'hBBBB1111, 1'b0, 4'd0, 1'b0, 4'd0);
      step("pre_rd", 1'b0, 4'd0,  32'h0,        1'b1, 4'd0, 1'b1, 4'd4);
      check("pre_q1_lit", q_1, 32'hCAFE0000);
      check("pre_q2_lit", q_2, 32'h44444444);

      // Asynchronous reset between edges clears outputs before the next edge
      #3 reset = 1'b1;
      model_clear();
      #1;
      check("async_rst_q1", q_1, 32'h0);
      check("async_rst_q2", q_2, 32'h0);
      // Writes attempted during reset must be ignored
      step("rst_hold0", 1'b1, 4'd4, 32'hFFFFFFFF, 1'b1, 4'd4, 1'b1, 4'd0);
      step("rst_hold1", 1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd4, 1'b1, 4'd0);
      reset = 1'b0;
      for (int a = 0; a < 16; a++) begin
         step("post_rst", 1'b0, 4'd0, 32'h0, 1'b1, 4'(a), 1'b1, 4'(a));
         check("post_rst_lit", q_1 | q_2, 32'h0);
      end

      // Basic writes and reads
      step("w3",  1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 4'd0);
      step("w15", 1'b1, 4'd15, 32'h12345678, 1'b0, 4'd0, 1'b0, 4'd0);
      step("r3_15", 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b1, 4'd15);
      check("r3_lit",  q_1, 32'hDEADBEEF);
      check("r15_lit", q_2, 32'h12345678);

      // Read-during-write collision returns old data, new data one edge later
      step("w5_old", 1'b1, 4'd5, 32'h11111111, 1'b0, 4'd0, 1'b0, 4'd0);
      step("rdw5",   1'b1, 4'd5, 32'h22222222, 1'b1, 4'd5, 1'b1, 4'd5);
      check("rdw_q1_old", q_1, 32'h11111111);
      check("rdw_q2_old", q_2, 32'h11111111);
      step("rdw5_nx", 1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b1, 4'd5);
      check("rdw_q1_new", q_1, 32'h22222222);
      check("rdw_q2_new", q_2, 32'h22222222);

      // Read enable low holds the output; the other port is independent
      step("w2", 1'b1, 4'd2, 32'hAAAA0000, 1'b0, 4'd0, 1'b0, 4'd0);
      step("w7", 1'b1, 4'd7, 32'h00000077, 1'b0, 4'd0, 1'b0, 4'd0);
      step("r2", 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b1, 4'd3);
      step("hold", 1'b0, 4'd0, 32'h0, 1'b0, 4'd7, 1'b1, 4'd15);
      check("hold_q1_lit", q_1, 32'hAAAA0000);
      check("hold_q2_lit", q_2, 32'h12345678);
      step("r7", 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b0, 4'd3);
      check("r7_lit", q_1, 32'h00000077);
      check("r7_q2_held", q_2, 32'h12345678);

      // wren low leaves storage untouched
      step("w9",    1'b1, 4'd9, 32'h00000009, 1'b0, 4'd0, 1'b0, 4'd0);
      step("nowr9", 1'b0, 4'd9, 32'hFFFFFFFF, 1'b0, 4'd0, 1'b0, 4'd0);
      step("r9",    1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 1'b1, 4'd9);
      check("r9_lit", q_1, 32'h00000009);

      // Fill all words, then sweep port 1 up and port 2 down
      for (int a = 0; a < 16; a++)
         step("fill", 1'b1, 4'(a), 32'(a) * 32'h01010101, 1'b0, 4'd0, 1'b0, 4'd0);
      for (int a = 0; a < 16; a++) begin
         step("sweep", 1'b0, 4'd0, 32'h0, 1'b1, 4'(a), 1'b1, 4'(15 - a));
         check("sweep_q1_lit", q_1, 32'(a) * 32'h01010101);
         check("sweep_q2_lit", q_2, 32'(15 - a) * 32'h01010101);
      end

      // Random traffic, with occasional mid-operation asynchronous resets
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            #2 reset = 1'b1;
            model_clear();
            #1;
            check("rnd_async_q1", q_1, 32'h0);
            check("rnd_async_q2", q_2, 32'h0);
            step("rnd_rst", 1'b1, 4'($urandom), $urandom, 1'b1, 4'($urandom), 1'b1, 4'($urandom));
            reset = 1'b0;
         end
         step("rnd", 1'($urandom), 4'($urandom), $urandom,
              1'($urandom_range(0, 3) != 0), 4'($urandom),
              1'($urandom_range(0, 3) != 0), 4'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
